// File: rtl/cpu_pkg.sv
// Shared opcode encodings and sequencer state type for the 8-bit core.
package cpu_pkg;

    localparam int OPW = 3;

    localparam logic [OPW-1:0] OP_LW     = 3'b000;
    localparam logic [OPW-1:0] OP_SW     = 3'b001;
    localparam logic [OPW-1:0] OP_AND    = 3'b010;
    localparam logic [OPW-1:0] OP_ADD    = 3'b011;
    localparam logic [OPW-1:0] OP_SHIFT  = 3'b100;
    localparam logic [OPW-1:0] OP_SET    = 3'b101;
    localparam logic [OPW-1:0] OP_XOR    = 3'b110;
    localparam logic [OPW-1:0] OP_BRANCH = 3'b111;

    typedef enum logic [2:0] {
        IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT, ERROR
    } st_t;

    function automatic logic is_mem_op(input logic [OPW-1:0] op);
        return (op == OP_LW) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/mem_watchdog.sv
// Counts cycles spent waiting on data memory; flags the last allowed cycle.
module mem_watchdog #(
    parameter int TMO_W       = 4,
    parameter int MEM_TIMEOUT = 12
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [TMO_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!reset)
            cnt <= '0;
        else if (clear)
            cnt <= '0;
        else if (enable)
            cnt <= cnt + 1'b1;
    end

    assign expired = (cnt == TMO_W'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle fetch/decode/execute sequencer with launch/halt control,
// data-memory watchdog and a saturating retired-instruction counter.
module instr_sequencer
    import cpu_pkg::*;
#(
    parameter int OPW         = 3,
    parameter int TMO_W       = 4,
    parameter int MEM_TIMEOUT = 12,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [OPW-1:0]   opcode,
    input  logic             branch_taken,
    input  logic             halt_req,
    input  logic             mem_ack,
    output logic             ir_load,
    output logic             pc_en,
    output logic             pc_branch,
    output logic             pc_clr,
    output logic             reg_we,
    output logic             mem_req,
    output logic             mem_we,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] retired
);

    st_t  state;
    logic start_q;
    logic launch;
    logic is_sw, is_br, is_mem;
    logic retire;
    logic wd_expired;

    assign launch = start & ~start_q;
    assign is_sw  = (opcode == OPW'(OP_SW));
    assign is_br  = (opcode == OPW'(OP_BRANCH));
    assign is_mem = is_mem_op(3'(opcode));

    assign retire = (state == EXEC && is_br)
                  || (state == MEM && mem_ack && is_sw)
                  || (state == WB);

    // Counter is held at zero outside MEM so every memory access starts fresh.
    mem_watchdog #(
        .TMO_W       (TMO_W),
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_wd (
        .clk     (clk),
        .reset   (reset),
        .clear   (state != MEM),
        .enable  ((state == MEM) && !mem_ack),
        .expired (wd_expired)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            start_q <= 1'b0;
            retired <= '0;
        end else begin
            start_q <= start;
            if ((state == IDLE || state == HALT) && launch)
                retired <= '0;
            else if (retire && retired != {CNT_W{1'b1}})
                retired <= retired + 1'b1;

            case (state)
                IDLE, HALT: if (launch) state <= FETCH;
                FETCH:      state <= DECODE;
                DECODE:     state <= halt_req ? HALT : EXEC;
                EXEC: begin
                    if (is_mem)     state <= MEM;
                    else if (is_br) state <= FETCH;
                    else            state <= WB;
                end
                // Ack wins over an expiring watchdog in the same cycle.
                MEM: begin
                    if (mem_ack)         state <= is_sw ? FETCH : WB;
                    else if (wd_expired) state <= ERROR;
                end
                WB:      state <= FETCH;
                ERROR:   state <= ERROR;
                default: state <= IDLE;
            endcase
        end
    end

    assign ir_load   = (state == FETCH);
    assign pc_clr    = (state == IDLE || state == HALT) && launch;
    assign pc_en     = retire;
    assign pc_branch = (state == EXEC) && is_br && branch_taken;
    assign reg_we    = (state == WB);
    assign mem_req   = (state == MEM);
    assign mem_we    = (state == MEM) && is_sw;
    assign done      = (state == HALT) || (state == ERROR);
    assign err       = (state == ERROR);

endmodule

// File: tb/tb_instr_sequencer.sv
// Scenario bench for instr_sequencer: each cycle's expected outputs are queued
// as stimulus is driven and checked against the DUT mid-cycle.
module tb_instr_sequencer;

    logic        clk = 1'b0;
    logic        reset, start, branch_taken, halt_req, mem_ack;
    logic [2:0]  opcode;
    logic        ir_load, pc_en, pc_branch, pc_clr, reg_we, mem_req, mem_we, done, err;
    logic [15:0] retired;

    instr_sequencer #(.OPW(3), .TMO_W(4), .MEM_TIMEOUT(12), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .start(start), .opcode(opcode),
        .branch_taken(branch_taken), .halt_req(halt_req), .mem_ack(mem_ack),
        .ir_load(ir_load), .pc_en(pc_en), .pc_branch(pc_branch), .pc_clr(pc_clr),
        .reg_we(reg_we), .mem_req(mem_req), .mem_we(mem_we), .done(done),
        .err(err), .retired(retired)
    );

    always #5 clk = ~clk;

    localparam logic [8:0] IRL = 9'h100, PCE = 9'h080, PCB = 9'h040, PCC = 9'h020,
                           RWE = 9'h010, MRQ = 9'h008, MWE = 9'h004, DN  = 9'h002,
                           ER  = 9'h001, NON = 9'h000;

    typedef struct {
        logic [8:0] outs;
        int         ret;
        string      tag;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   n_tests = 0;
    int   n_fail  = 0;

    wire [8:0] obs = {ir_load, pc_en, pc_branch, pc_clr, reg_we, mem_req, mem_we, done, err};

    always @(negedge clk) begin
        if (q.size() > 0) begin
            mon_e = q.pop_front();
            n_tests++;
            if (obs !== mon_e.outs) begin
                n_fail++;
                $display("FAIL %s outs got %b want %b (ir pce pcb clr rwe mrq mwe dn er)",
                         mon_e.tag, obs, mon_e.outs);
            end
            if (mon_e.ret >= 0) begin
                n_tests++;
                if (retired !== 16'(mon_e.ret)) begin
                    n_fail++;
                    $display("FAIL %s retired got %0d want %0d", mon_e.tag, retired, mon_e.ret);
                end
            end
        end
    end

    task automatic cyc(input logic [8:0] o, input int r, input string t);
        q.push_back('{outs: o, ret: r, tag: t});
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b0; opcode = 3'b000;
        branch_taken = 1'b0; halt_req = 1'b0; mem_ack = 1'b0;
        @(posedge clk);
        #1;
        cyc(NON, 0, "rst0");
        cyc(NON, 0, "rst1");
        reset = 1'b1;
        cyc(NON, 0, "idle");
    endtask

    task automatic test_alu_halt();
        start = 1'b1;
        cyc(PCC, 0, "launch");
        start = 1'b0; opcode = 3'b011;
        cyc(IRL, 0, "add_fetch");
        cyc(NON, -1, "add_dec");
        cyc(NON, -1, "add_exec");
        cyc(RWE | PCE, 0, "add_wb");
        opcode = 3'b110;
        cyc(IRL, 1, "xor_fetch");
        cyc(NON, -1, "xor_dec");
        cyc(NON, -1, "xor_exec");
        cyc(RWE | PCE, 1, "xor_wb");
        cyc(IRL, 2, "fetch3");
        halt_req = 1'b1;
        cyc(NON, 2, "halt_dec");
        halt_req = 1'b0;
        cyc(DN, 2, "halt");
        cyc(DN, 2, "halt_stay");
    endtask

    task automatic test_mem_branch();
        start = 1'b1;
        cyc(DN | PCC, 2, "relaunch");
        start = 1'b0; opcode = 3'b000;
        cyc(IRL, 0, "lw_fetch");
        cyc(NON, -1, "lw_dec");
        cyc(NON, -1, "lw_exec");
        cyc(MRQ, 0, "lw_mem1");
        cyc(MRQ, 0, "lw_mem2");
        mem_ack = 1'b1;
        cyc(MRQ, 0, "lw_mem_ack");
        mem_ack = 1'b0;
        cyc(RWE | PCE, 0, "lw_wb");
        opcode = 3'b001;
        cyc(IRL, 1, "sw_fetch");
        cyc(NON, -1, "sw_dec");
        cyc(NON, -1, "sw_exec");
        mem_ack = 1'b1;
        cyc(MRQ | MWE | PCE, 1, "sw_ack");
        mem_ack = 1'b0; opcode = 3'b111;
        cyc(IRL, 2, "br_fetch");
        cyc(NON, -1, "br_dec");
        branch_taken = 1'b1;
        cyc(PCE | PCB, 2, "br_taken");
        branch_taken = 1'b0;
        cyc(IRL, 3, "br2_fetch");
        cyc(NON, -1, "br2_dec");
        cyc(PCE, 3, "br_not_taken");
        cyc(IRL, 4, "fetch_end");
        halt_req = 1'b1;
        cyc(NON, 4, "halt_dec");
        halt_req = 1'b0;
        cyc(DN, 4, "halt");
    endtask

    task automatic test_ack_at_limit();
        start = 1'b1;
        cyc(DN | PCC, 4, "lim_launch");
        start = 1'b0; opcode = 3'b000;
        cyc(IRL, 0, "lim_fetch");
        cyc(NON, -1, "lim_dec");
        cyc(NON, -1, "lim_exec");
        for (int i = 0; i < 11; i++) cyc(MRQ, 0, "lim_wait");
        mem_ack = 1'b1;
        cyc(MRQ, 0, "lim_ack12");
        mem_ack = 1'b0;
        cyc(RWE | PCE, 0, "lim_wb");
        cyc(IRL, 1, "lim_fetch2");
        halt_req = 1'b1;
        cyc(NON, 1, "lim_hdec");
        halt_req = 1'b0;
        cyc(DN, 1, "lim_halt");
    endtask

    task automatic test_timeout();
        start = 1'b1;
        cyc(DN | PCC, 1, "to_launch");
        start = 1'b0; opcode = 3'b011;
        cyc(IRL, 0, "to_add_fetch");
        cyc(NON, -1, "to_add_dec");
        cyc(NON, -1, "to_add_exec");
        cyc(RWE | PCE, 0, "to_add_wb");
        opcode = 3'b000;
        cyc(IRL, 1, "to_lw_fetch");
        cyc(NON, -1, "to_lw_dec");
        cyc(NON, -1, "to_lw_exec");
        for (int i = 0; i < 12; i++) cyc(MRQ, 1, "to_wait");
        cyc(DN | ER, 1, "to_error");
        start = 1'b1;
        cyc(DN | ER, 1, "to_err_start");
        start = 1'b0;
        cyc(DN | ER, 1, "to_err_hold");
        start = 1'b1;
        cyc(DN | ER, 1, "to_err_start2");
        start = 1'b0; mem_ack = 1'b1;
        cyc(DN | ER, 1, "to_err_lateack");
        mem_ack = 1'b0; reset = 1'b0;
        cyc(DN | ER, 1, "to_err_in_rst");
        reset = 1'b1;
        cyc(NON, 0, "to_post_rst");
    endtask

    task automatic test_start_held();
        start = 1'b1; opcode = 3'b101;
        cyc(PCC, 0, "sh_launch");
        cyc(IRL, 0, "sh_fetch");
        cyc(NON, -1, "sh_dec");
        cyc(NON, -1, "sh_exec");
        cyc(RWE | PCE, 0, "sh_wb");
        cyc(IRL, 1, "sh_fetch2");
        halt_req = 1'b1;
        cyc(NON, 1, "sh_hdec");
        halt_req = 1'b0;
        for (int i = 0; i < 3; i++) cyc(DN, 1, "sh_halt_held");
        start = 1'b0;
        cyc(DN, 1, "sh_halt_low");
        start = 1'b1;
        cyc(DN | PCC, 1, "sh_relaunch");
        start = 1'b0; opcode = 3'b000;
        cyc(IRL, 0, "sh_fetch_new");
    endtask

    task automatic test_reset_mid_mem();
        cyc(NON, -1, "rm_dec");
        cyc(NON, -1, "rm_exec");
        cyc(MRQ, 0, "rm_mem");
        reset = 1'b0;
        cyc(MRQ, 0, "rm_mem_in_rst");
        reset = 1'b1; mem_ack = 1'b1;
        cyc(NON, 0, "rm_idle_lateack");
        mem_ack = 1'b0;
        cyc(NON, 0, "rm_idle");
    endtask

    initial begin
        test_reset();
        test_alu_halt();
        test_mem_branch();
        test_ack_at_limit();
        test_timeout();
        test_start_held();
        test_reset_mid_mem();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
